nand_one: RTL and testbench
===========================

Name: nand_one

Overview:
- Two-input bitwise NAND cell. It provides a combinational output and a registered, valid-qualified output.
- It also tracks which input combinations (truth-table rows) have been applied, for on-chip self-characterisation.
- It is a leaf primitive used wherever a NAND with optional pipelining and row coverage is needed.

Parameters:
- WIDTH, 1, bit width of A, B, Y and y_q.
- CNT_W, 16, width of each per-row hit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- in_valid  input  1  qualifies A/B for the registered path and the counters.
- clr  input  1  synchronous clear of the counters and seen flags only.
- Y  output  WIDTH  combinational ~(A & B).
- y_q  output  WIDTH  registered ~(A & B), captured when in_valid=1.
- out_valid  output  1  high exactly one cycle after each accepted in_valid.
- row_seen  output  4  sticky flag per row; the bit index equals {A[0],B[0]}.
- all_seen  output  1  high when row_seen is 4'b1111.
- cnt00, cnt01, cnt10, cnt11  output  CNT_W each  accepted-sample count per {A[0],B[0]} row.

Behaviour:
- Combinational path:
  - Y = ~(A & B), bitwise, at all times.
  - Y does not depend on clk, rst_n, in_valid or clr, and is valid during reset.
  - Y settles within the same simulation delta after an A/B change.
- Reset: all registered state is sampled on the clk rising edge when rst_n=0. Values during reset:
  - y_q = all ones (the NAND of zero operands).
  - out_valid = 0.
  - row_seen = 0, all_seen = 0.
  - all counters = 0.
- Registered path, one-cycle latency:
  - On an edge with in_valid=1: y_q <= ~(A & B) and out_valid <= 1.
  - On an edge with in_valid=0: y_q holds its value and out_valid <= 0.
  - There is no backpressure; every in_valid is accepted.
- Row tracking, on an edge with in_valid=1 and clr=0:
  - The row index r = {A[0],B[0]}.
  - row_seen[r] <= 1.
  - cnt_r increments by 1 and saturates at 2^CNT_W-1, with no wrap.
  - Only bit 0 of A and B selects the row, regardless of WIDTH.
- clr (rst_n=1):
  - clr=1 zeroes the counters and row_seen on that edge.
  - If clr and in_valid occur on the same edge, clr wins: counters and row_seen become 0 and the sample is not counted.
  - The y_q/out_valid path still updates normally.
- all_seen is combinational from row_seen (&row_seen).
- Reset mid-operation: reset takes priority over everything and clears state on that edge. The first accepted sample after reset release produces out_valid on the following cycle.
- The block contains no X-propagation handling: A and B are required to be known whenever in_valid=1.

Test Plan:
- Combinational truth table, WIDTH=1, no clock edges: A,B = 00, 01, 10, 11, each held 10 time units -> Y = 1, 1, 1, 0 respectively.
- Reset: rst_n=0 for 2 edges with A=1,B=1,in_valid=1 -> y_q=1, out_valid=0, counters=0, row_seen=0; Y=0 throughout.
- Registered latency: release reset, apply 00,01,10,11 with in_valid=1 on consecutive edges:
  - y_q = 1, 1, 1, 0 one cycle after each sample, with out_valid=1.
  - After the sequence: row_seen=1111, all_seen=1 and each counter=1.
  - Dropping in_valid -> out_valid=0 and y_q holds 0.
- Multi-bit, WIDTH=4: A=4'b1100, B=4'b1010 -> Y=4'b0111; y_q=4'b0111 on the next edge. The sample counts into cnt00, since A[0]=0 and B[0]=0.
- Clear priority: with cnt11=5, assert clr and in_valid with A=B=1 on the same edge -> cnt11=0, row_seen=0, y_q=0, out_valid=1.
- Saturation, CNT_W=2: apply row 01 five times -> cnt01 = 1, 2, 3, 3, 3; other counters remain 0.

Source files
------------

// File: rtl/nand_one.sv
// Two-input bitwise NAND with a registered valid-qualified copy and
// per-row hit counters for on-chip truth-table coverage.
module nand_one #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             in_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic [3:0]       row_seen,
    output logic             all_seen,
    output logic [CNT_W-1:0] cnt00,
    output logic [CNT_W-1:0] cnt01,
    output logic [CNT_W-1:0] cnt10,
    output logic [CNT_W-1:0] cnt11
);

    logic [1:0]       row;
    logic [CNT_W-1:0] cnt_r [4];

    assign Y        = ~(A & B);
    assign row      = {A[0], B[0]};
    assign all_seen = &row_seen;

    assign cnt00 = cnt_r[0];
    assign cnt01 = cnt_r[1];
    assign cnt10 = cnt_r[2];
    assign cnt11 = cnt_r[3];

    // clr only touches coverage state; the data path keeps running.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q       <= '1;
            out_valid <= 1'b0;
            row_seen  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y_q <= ~(A & B);
            end
            if (clr) begin
                row_seen <= '0;
                for (int i = 0; i < 4; i++) begin
                    cnt_r[i] <= '0;
                end
            end else if (in_valid) begin
                row_seen[row] <= 1'b1;
                if (cnt_r[row] != {CNT_W{1'b1}}) begin
                    cnt_r[row] <= cnt_r[row] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nand_one.sv
// Bench for nand_one: a 1-bit/16-bit-counter instance and a 4-bit/2-bit-counter
// instance share stimulus and are checked against a count-based reference model.
`timescale 1ns/1ps
module tb_nand_one;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n;
    logic [3:0] A4, B4;
    logic       A1, B1;
    logic       in_valid, clr;

    logic        y1, yq1, ov1, as1;
    logic [3:0]  rs1;
    logic [15:0] c1_00, c1_01, c1_10, c1_11;
    logic [3:0]  y4, yq4, rs4;
    logic        ov4, as4;
    logic [1:0]  c4_00, c4_01, c4_10, c4_11;

    int n_checks = 0;
    int n_fail   = 0;

    assign A1 = A4[0];
    assign B1 = B4[0];

    always #5 if (clk_en) clk = ~clk;

    nand_one #(.WIDTH(1), .CNT_W(16)) u_w1 (
        .clk(clk), .rst_n(rst_n), .A(A1), .B(B1), .in_valid(in_valid), .clr(clr),
        .Y(y1), .y_q(yq1), .out_valid(ov1), .row_seen(rs1), .all_seen(as1),
        .cnt00(c1_00), .cnt01(c1_01), .cnt10(c1_10), .cnt11(c1_11));

    nand_one #(.WIDTH(4), .CNT_W(2)) u_w4 (
        .clk(clk), .rst_n(rst_n), .A(A4), .B(B4), .in_valid(in_valid), .clr(clr),
        .Y(y4), .y_q(yq4), .out_valid(ov4), .row_seen(rs4), .all_seen(as4),
        .cnt00(c4_00), .cnt01(c4_01), .cnt10(c4_10), .cnt11(c4_11));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] nand_of(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = !(a[i] && b[i]);
        return r;
    endfunction

    // Reference model: hit counts per row as plain integers; a row is "seen"
    // exactly when its count is non-zero, since only clr/reset zero both.
    bit         m_init = 0;
    logic       m_yq1;
    logic [3:0] m_yq4;
    bit         m_ov;
    int         m_cnt1 [4];
    int         m_cnt4 [4];

    always @(posedge clk) begin
        int r;
        if (!rst_n) begin
            m_init = 1;
            m_yq1  = 1'b1;
            m_yq4  = 4'hF;
            m_ov   = 0;
            for (int i = 0; i < 4; i++) begin m_cnt1[i] = 0; m_cnt4[i] = 0; end
        end else if (m_init) begin
            m_ov = in_valid;
            if (in_valid) begin
                m_yq1 = nand_of({3'b0, A1}, {3'b0, B1})[0];
                m_yq4 = nand_of(A4, B4);
            end
            if (clr) begin
                for (int i = 0; i < 4; i++) begin m_cnt1[i] = 0; m_cnt4[i] = 0; end
            end else if (in_valid) begin
                r = 2 * int'(A4[0]) + int'(B4[0]);
                m_cnt1[r] = (m_cnt1[r] + 1 > 65535) ? 65535 : m_cnt1[r] + 1;
                m_cnt4[r] = (m_cnt4[r] + 1 > 3) ? 3 : m_cnt4[r] + 1;
            end
        end
    end

    function automatic logic [3:0] seen_of(input int c0, input int c1, input int c2, input int c3);
        return {c3 != 0, c2 != 0, c1 != 0, c0 != 0};
    endfunction

    always @(negedge clk) begin
        if (clk_en) begin
            chk("y1", 32'(y1), 32'(nand_of({3'b0, A1}, {3'b0, B1})[0]));
            chk("y4", 32'(y4), 32'(nand_of(A4, B4)));
            if (m_init) begin
                chk("yq1", 32'(yq1), 32'(m_yq1));
                chk("yq4", 32'(yq4), 32'(m_yq4));
                chk("ov1", 32'(ov1), 32'(m_ov));
                chk("ov4", 32'(ov4), 32'(m_ov));
                chk("rs1", 32'(rs1), 32'(seen_of(m_cnt1[0], m_cnt1[1], m_cnt1[2], m_cnt1[3])));
                chk("rs4", 32'(rs4), 32'(seen_of(m_cnt4[0], m_cnt4[1], m_cnt4[2], m_cnt4[3])));
                chk("as1", 32'(as1), 32'(&seen_of(m_cnt1[0], m_cnt1[1], m_cnt1[2], m_cnt1[3])));
                chk("as4", 32'(as4), 32'(&seen_of(m_cnt4[0], m_cnt4[1], m_cnt4[2], m_cnt4[3])));
                chk("c1_00", 32'(c1_00), m_cnt1[0]);
                chk("c1_01", 32'(c1_01), m_cnt1[1]);
                chk("c1_10", 32'(c1_10), m_cnt1[2]);
                chk("c1_11", 32'(c1_11), m_cnt1[3]);
                chk("c4_00", 32'(c4_00), m_cnt4[0]);
                chk("c4_01", 32'(c4_01), m_cnt4[1]);
                chk("c4_10", 32'(c4_10), m_cnt4[2]);
                chk("c4_11", 32'(c4_11), m_cnt4[3]);
            end
        end
    end

    // Drive inputs shortly after a rising edge, then advance past the next one.
    task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic v,
                         input logic c, input logic r);
        A4 = a; B4 = b; in_valid = v; clr = c; rst_n = r;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] tt_exp;
        logic [1:0] sat_exp [5];
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; A4 = '0; B4 = '0;

        tt_exp = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            A4 = {3'b0, 1'(i >> 1)};
            B4 = {3'b0, 1'(i & 1)};
            #10;
            chk("tt_y1", 32'(y1), 32'(tt_exp[i]));
        end

        A4 = 4'hF; B4 = 4'hF; in_valid = 1'b1;
        clk_en = 1'b1;
        apply(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        apply(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        chk("rst_yq1", 32'(yq1), 32'd1);
        chk("rst_ov1", 32'(ov1), 32'd0);
        chk("rst_c11", 32'(c1_11), 32'd0);
        chk("rst_rs1", 32'(rs1), 32'd0);
        chk("rst_y1", 32'(y1), 32'd0);

        for (int i = 0; i < 4; i++) begin
            apply({3'b0, 1'(i >> 1)}, {3'b0, 1'(i & 1)}, 1'b1, 1'b0, 1'b1);
            chk("lat_yq1", 32'(yq1), 32'(tt_exp[i]));
            chk("lat_ov1", 32'(ov1), 32'd1);
        end
        chk("seq_rs1", 32'(rs1), 32'hF);
        chk("seq_as1", 32'(as1), 32'd1);
        chk("seq_c00", 32'(c1_00), 32'd1);
        chk("seq_c10", 32'(c1_10), 32'd1);
        apply(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        chk("idle_ov1", 32'(ov1), 32'd0);
        chk("idle_yq1", 32'(yq1), 32'd0);

        A4 = 4'b1100; B4 = 4'b1010; #1;
        chk("mb_y4", 32'(y4), 32'b0111);
        apply(4'b1100, 4'b1010, 1'b1, 1'b0, 1'b1);
        chk("mb_yq4", 32'(yq4), 32'b0111);
        chk("mb_c00", 32'(c4_00), 32'd2);

        apply(4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) apply(4'h1, 4'h1, 1'b1, 1'b0, 1'b1);
        chk("pre_c11", 32'(c1_11), 32'd5);
        apply(4'h1, 4'h1, 1'b1, 1'b1, 1'b1);
        chk("clr_c11", 32'(c1_11), 32'd0);
        chk("clr_rs1", 32'(rs1), 32'd0);
        chk("clr_yq1", 32'(yq1), 32'd0);
        chk("clr_ov1", 32'(ov1), 32'd1);

        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
        sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            apply(4'h0, 4'h1, 1'b1, 1'b0, 1'b1);
            chk("sat_c01", 32'(c4_01), 32'(sat_exp[i]));
            chk("sat_c00", 32'(c4_00), 32'd0);
        end

        for (int i = 0; i < 600; i++) begin
            apply(4'($urandom), 4'($urandom), 1'($urandom),
                  $urandom_range(0, 19) == 0, $urandom_range(0, 49) != 0);
        end

        clk_en = 1'b0;
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
